mem_access_ctrl: RTL and testbench



---
 rtl/mem_access_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Load/store memory sequencer: byte enables, lane shifting, load extension, error reporting.
// Define SPLIT_MISALIGNED_EN to split boundary-crossing accesses into two beats.
module mem_access_ctrl #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [XLEN-1:0]      req_wdata,
  output logic                 rsp_valid,
  output logic                 rsp_error,
  output logic [XLEN-1:0]      rsp_rdata,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [ADDR_W-1:0]    mem_address,
  output logic [XLEN-1:0]      mem_wdata,
  output logic [XLEN/8-1:0]    mem_byte_enable,
  input  logic [XLEN-1:0]      mem_rdata,
  input  logic                 mem_resp,
  output logic [XLEN/8-1:0]    rmask,
  output logic [XLEN/8-1:0]    wmask
);

  // state | meaning
  // IDLE  | ready for a request
  // BEAT1 | first (or only) memory beat, held until mem_resp
  // BEAT2 | upper half of a boundary-crossing access
  // RESP  | one-cycle response strobe

  localparam int BYTES = XLEN / 8;
  localparam int OFS_W = $clog2(BYTES);

  typedef enum logic [1:0] {IDLE, BEAT1, BEAT2, RESP} state_t;

  state_t                state_q, state_d;
  logic                  write_q, write_d;
  logic                  unsigned_q, unsigned_d;
  logic                  error_q, error_d;
  logic [1:0]            size_q, size_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [2*XLEN-1:0]     wshift_q, wshift_d;
  logic [2*BYTES-1:0]    mask_q, mask_d;
  logic [XLEN-1:0]       beat1_q, beat1_d;
  logic [XLEN-1:0]       beat2_q, beat2_d;

  logic [OFS_W-1:0]      ofs_in;
  logic [2*BYTES-1:0]    base_mask;
  logic [2*BYTES-1:0]    new_mask;
  logic [2*XLEN-1:0]     new_wshift;
  logic                  misaligned;
  logic                  size_bad;
  logic                  illegal;
  int                    nbytes_in;

  assign ofs_in = req_addr[OFS_W-1:0];

  always_comb begin
    nbytes_in = 1 << req_size;
    base_mask = '0;
    for (int i = 0; i < 2*BYTES; i++) begin
      base_mask[i] = (i < nbytes_in);
    end
    new_mask   = base_mask << ofs_in;
    new_wshift = {{XLEN{1'b0}}, req_wdata} << {ofs_in, 3'b000};
    misaligned = (int'(ofs_in) + nbytes_in) > BYTES;
    size_bad   = (req_size == 2'd3) && (XLEN == 32);
`ifdef SPLIT_MISALIGNED_EN
    illegal    = size_bad;
`else
    illegal    = size_bad || misaligned;
`endif
  end

  logic [ADDR_W-1:0]   beat1_addr;
  logic [ADDR_W-1:0]   beat2_addr;
  logic [OFS_W-1:0]    ofs_q;
  logic [2*XLEN-1:0]   raw_wide;
  logic [XLEN-1:0]     raw;
  logic [XLEN-1:0]     load_ext;
  logic                sign_bit;
  int                  nbits;

  assign ofs_q      = addr_q[OFS_W-1:0];
  assign beat1_addr = {addr_q[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
  assign beat2_addr = beat1_addr + ADDR_W'(BYTES);
  assign raw_wide   = {beat2_q, beat1_q} >> {ofs_q, 3'b000};
  assign raw        = raw_wide[XLEN-1:0];

  // Replicate either the loaded MSB or zero above the access width.
  always_comb begin
    nbits    = 8 << size_q;
    load_ext = raw;
    sign_bit = 1'b0;
    if (nbits < XLEN) begin
      sign_bit = raw[nbits-1] & ~unsigned_q;
      for (int i = 0; i < XLEN; i++) begin
        load_ext[i] = (i < nbits) ? raw[i] : sign_bit;
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    req_ready       = 1'b0;
    rsp_valid       = 1'b0;
    rsp_error       = 1'b0;
    rsp_rdata       = '0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_address     = '0;
    mem_wdata       = '0;
    mem_byte_enable = '1;
    rmask           = '0;
    wmask           = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d = illegal ? RESP : BEAT1;
        end
      end
      BEAT1: begin
        mem_read    = ~write_q;
        mem_write   = write_q;
        mem_address = beat1_addr;
        mem_wdata   = wshift_q[XLEN-1:0];
        if (write_q) begin
          mem_byte_enable = mask_q[BYTES-1:0];
          wmask           = mask_q[BYTES-1:0];
        end else begin
          rmask           = mask_q[BYTES-1:0];
        end
        if (mem_resp) begin
          state_d = (|mask_q[2*BYTES-1:BYTES]) ? BEAT2 : RESP;
        end
      end
      BEAT2: begin
        mem_read    = ~write_q;
        mem_write   = write_q;
        mem_address = beat2_addr;
        mem_wdata   = wshift_q[2*XLEN-1:XLEN];
        if (write_q) begin
          mem_byte_enable = mask_q[2*BYTES-1:BYTES];
          wmask           = mask_q[2*BYTES-1:BYTES];
        end else begin
          rmask           = mask_q[2*BYTES-1:BYTES];
        end
        if (mem_resp) begin
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_error = error_q;
        rsp_rdata = (error_q || write_q) ? '0 : load_ext;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    write_d    = write_q;
    unsigned_d = unsigned_q;
    error_d    = error_q;
    size_d     = size_q;
    addr_d     = addr_q;
    wshift_d   = wshift_q;
    mask_d     = mask_q;
    beat1_d    = beat1_q;
    beat2_d    = beat2_q;
    if (state_q == IDLE && req_valid) begin
      write_d    = req_write;
      unsigned_d = req_unsigned;
      error_d    = illegal;
      size_d     = req_size;
      addr_d     = req_addr;
      wshift_d   = new_wshift;
      mask_d     = new_mask;
      beat1_d    = '0;
      beat2_d    = '0;
    end
    if (state_q == BEAT1 && mem_resp && !write_q) begin
      beat1_d = mem_rdata;
    end
    if (state_q == BEAT2 && mem_resp && !write_q) begin
      beat2_d = mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      write_q    <= 1'b0;
      unsigned_q <= 1'b0;
      error_q    <= 1'b0;
      size_q     <= 2'd0;
      addr_q     <= '0;
      wshift_q   <= '0;
      mask_q     <= '0;
      beat1_q    <= '0;
      beat2_q    <= '0;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      unsigned_q <= unsigned_d;
      error_q    <= error_d;
      size_q     <= size_d;
      addr_q     <= addr_d;
      wshift_q   <= wshift_d;
      mask_q     <= mask_d;
      beat1_q    <= beat1_d;
      beat2_q    <= beat2_d;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a 32-bit and a 64-bit instance, hand-computed expectations.
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_valid64;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic [63:0] mem_rdata;
  logic        mem_resp, mem_resp64;

  logic        req_ready, rsp_valid, rsp_error, mem_read, mem_write;
  logic [31:0] rsp_rdata, mem_address, mem_wdata;
  logic [3:0]  mem_byte_enable, rmask, wmask;

  logic        req_ready64, rsp_valid64, rsp_error64, mem_read64, mem_write64;
  logic [63:0] rsp_rdata64, mem_wdata64;
  logic [31:0] mem_address64;
  logic [7:0]  mem_byte_enable64, rmask64, wmask64;

  int tests_run = 0;
  int tests_failed = 0;

  mem_access_ctrl #(.XLEN(32), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata[31:0]),
    .rsp_valid(rsp_valid), .rsp_error(rsp_error), .rsp_rdata(rsp_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_rdata(mem_rdata[31:0]), .mem_resp(mem_resp),
    .rmask(rmask), .wmask(wmask)
  );

  mem_access_ctrl #(.XLEN(64), .ADDR_W(32)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid64), .req_ready(req_ready64), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid64), .rsp_error(rsp_error64), .rsp_rdata(rsp_rdata64),
    .mem_read(mem_read64), .mem_write(mem_write64), .mem_address(mem_address64),
    .mem_wdata(mem_wdata64), .mem_byte_enable(mem_byte_enable64),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp64),
    .rmask(rmask64), .wmask(wmask64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge of T+1.
  task automatic issue(input logic sel64, input logic wr, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr, input logic [63:0] wd);
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    if (sel64) req_valid64 = 1'b1;
    else       req_valid   = 1'b1;
    @(negedge clk);
    req_valid   = 1'b0;
    req_valid64 = 1'b0;
  endtask

  // Zero-wait completion of the current beat; returns at the next negedge.
  task automatic beat(input logic sel64, input logic [63:0] rd);
    mem_rdata = rd;
    if (sel64) mem_resp64 = 1'b1;
    else       mem_resp   = 1'b1;
    @(negedge clk);
    mem_resp   = 1'b0;
    mem_resp64 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_valid64 = 1'b0; req_write = 1'b0;
    req_size = 2'd0; req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    mem_rdata = '0; mem_resp = 1'b0; mem_resp64 = 1'b0;
    #12;
    chk("rst_ready", req_ready, 1);
    chk("rst_be", mem_byte_enable, 64'hF);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_addr", mem_address, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // lw 0x100 with two wait cycles
    issue(0, 0, 2'd2, 0, 32'h100, 0);
    chk("lw_read", mem_read, 1);
    chk("lw_addr", mem_address, 32'h100);
    chk("lw_rmask", rmask, 64'hF);
    chk("lw_wmask", wmask, 0);
    chk("lw_be", mem_byte_enable, 64'hF);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("lw_wait_read", mem_read, 1);
      chk("lw_wait_rsp", rsp_valid, 0);
    end
    beat(0, 64'h8899AABB);
    chk("lw_rsp_valid", rsp_valid, 1);
    chk("lw_rdata", rsp_rdata, 64'h8899AABB);
    chk("lw_err", rsp_error, 0);
    chk("lw_rsp_read", mem_read, 0);
    chk("lw_rsp_ready", req_ready, 0);
    chk("lw_rsp_rmask", rmask, 0);
    @(negedge clk);
    chk("lw_done_valid", rsp_valid, 0);
    chk("lw_done_ready", req_ready, 1);

    // lb / lbu 0x103
    issue(0, 0, 2'd0, 0, 32'h103, 0);
    chk("lb_rmask", rmask, 64'h8);
    chk("lb_addr", mem_address, 32'h100);
    beat(0, 64'h80112233);
    chk("lb_rdata", rsp_rdata, 64'hFFFFFF80);
    @(negedge clk);
    issue(0, 0, 2'd0, 1, 32'h103, 0);
    beat(0, 64'h80112233);
    chk("lbu_rdata", rsp_rdata, 64'h00000080);
    @(negedge clk);

    // lh 0x101: misaligned inside the word, still legal
    issue(0, 0, 2'd1, 0, 32'h101, 0);
    chk("lh1_rmask", rmask, 64'h6);
    chk("lh1_read", mem_read, 1);
    beat(0, 64'h00ABCD00);
    chk("lh1_err", rsp_error, 0);
    chk("lh1_rdata", rsp_rdata, 64'hFFFFABCD);
    @(negedge clk);

    // sh 0x102
    issue(0, 1, 2'd1, 0, 32'h102, 64'h1234);
    chk("sh_write", mem_write, 1);
    chk("sh_read", mem_read, 0);
    chk("sh_addr", mem_address, 32'h100);
    chk("sh_be", mem_byte_enable, 64'hC);
    chk("sh_wmask", wmask, 64'hC);
    chk("sh_wdata", mem_wdata, 64'h12340000);
    beat(0, 64'hDEADBEEF);
    chk("sh_rsp", rsp_valid, 1);
    chk("sh_err", rsp_error, 0);
    chk("sh_rdata", rsp_rdata, 0);
    @(negedge clk);

    // sw 0x0FE crosses the word boundary
    issue(0, 1, 2'd2, 0, 32'h0FE, 64'hAABBCCDD);
`ifdef SPLIT_MISALIGNED_EN
    chk("swx_b1_addr", mem_address, 32'h0FC);
    chk("swx_b1_be", mem_byte_enable, 64'hC);
    chk("swx_b1_wdata", mem_wdata, 64'hCCDD0000);
    beat(0, 0);
    chk("swx_b2_write", mem_write, 1);
    chk("swx_b2_addr", mem_address, 32'h100);
    chk("swx_b2_be", mem_byte_enable, 64'h3);
    chk("swx_b2_wdata", mem_wdata, 64'h0000AABB);
    beat(0, 0);
    chk("swx_rsp", rsp_valid, 1);
    chk("swx_err", rsp_error, 0);
`else
    chk("swx_rsp", rsp_valid, 1);
    chk("swx_err", rsp_error, 1);
    chk("swx_write", mem_write, 0);
    chk("swx_rdata", rsp_rdata, 0);
`endif
    @(negedge clk);

    // dword on the 32-bit instance is rejected
    issue(0, 0, 2'd3, 0, 32'h8, 0);
    chk("d32_rsp", rsp_valid, 1);
    chk("d32_err", rsp_error, 1);
    chk("d32_read", mem_read, 0);
    @(negedge clk);

    // 64-bit instance: ld 0x8 and lw 0xC
    issue(1, 0, 2'd3, 0, 32'h8, 0);
    chk("ld_addr", mem_address64, 32'h8);
    chk("ld_rmask", rmask64, 64'hFF);
    chk("ld_be", mem_byte_enable64, 64'hFF);
    beat(1, 64'h0123456789ABCDEF);
    chk("ld_rsp", rsp_valid64, 1);
    chk("ld_err", rsp_error64, 0);
    chk("ld_rdata", rsp_rdata64, 64'h0123456789ABCDEF);
    @(negedge clk);
    issue(1, 0, 2'd2, 0, 32'hC, 0);
    chk("lw64_addr", mem_address64, 32'h8);
    chk("lw64_rmask", rmask64, 64'hF0);
    beat(1, 64'h0123456789ABCDEF);
    chk("lw64_rdata", rsp_rdata64, 64'h0000000001234567);
    @(negedge clk);

    // async reset during BEAT1, then a late mem_resp
    issue(0, 0, 2'd2, 0, 32'h200, 0);
    chk("rbt_read", mem_read, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rbt_read_off", mem_read, 0);
    chk("rbt_ready", req_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    beat(0, 64'h11111111);
    chk("rbt_late_rsp", rsp_valid, 0);
    chk("rbt_late_read", mem_read, 0);
    chk("rbt_late_ready", req_ready, 1);
    issue(0, 0, 2'd2, 0, 32'h204, 0);
    chk("rbt_next_addr", mem_address, 32'h204);
    beat(0, 64'h76543210);
    chk("rbt_next_rsp", rsp_valid, 1);
    chk("rbt_next_rdata", rsp_rdata, 64'h76543210);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
